keypad_emulator: RTL and testbench

Responder side of the 4x4 matrix keypad interface: watches the one-hot column strobe driven by the keypad scanner and answers on the row lines as if a physical key were pressed. A key code is accepted on a valid/ready handshake. The key is held for a programmable number of column sweeps, then released for a programmable number of sweeps, and completion is reported. The block is used for board self-test and for closed-loop simulation of the scanner and its consumers without a real keypad.

---
 rtl/keypad_emulator.sv | 257 +++++++++++++++++++++++++
 tb/tb_keypad_emulator.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_emulator.sv
// -----------------------------------------------------------------------------
// keypad_emulator
//
// Answers the column strobe of a 4x4 matrix keypad scanner on the row lines as
// if one physical key were pressed. A key code is accepted on a valid/ready
// handshake. The key is then shown pressed for HOLD_SCANS target-column
// windows and shown released for GAP_SCANS windows, after which `done` pulses.
// If the column strobe stops changing for TIMEOUT_CYC cycles while a sequence
// is active, the sequence aborts and `err` pulses.
//
// Parameters
//   HOLD_SCANS   target-column windows shown pressed (>= 1)
//   GAP_SCANS    target-column windows shown released before done (>= 1)
//   TIMEOUT_CYC  cycles without a change on the synchronized column strobe
//                before an active sequence aborts
//
// Ports
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   col        one-hot column strobe from the scanner (asynchronous)
//   fila       emulated row lines, one-hot while the key is shown pressed
//   key_valid  key_code is offered
//   key_code   [3:2] column index, [1:0] row index
//   key_ready  a code can be accepted this cycle
//   busy       a press/release sequence is in progress
//   done       one-cycle pulse on normal completion
//   err        one-cycle pulse on timeout abort
// -----------------------------------------------------------------------------
module keypad_emulator #(
    parameter int HOLD_SCANS  = 4,
    parameter int GAP_SCANS   = 2,
    parameter int TIMEOUT_CYC = 1048576
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] col,
    output logic [3:0] fila,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic       key_ready,
    output logic       busy,
    output logic       done,
    output logic       err
);

    // -------------------------------------------------------------------------
    // Counter geometry
    // -------------------------------------------------------------------------
    localparam int SCAN_MAX = (HOLD_SCANS > GAP_SCANS) ? HOLD_SCANS : GAP_SCANS;
    localparam int SCAN_W   = $clog2(SCAN_MAX + 1);
    localparam int TO_W     = $clog2(TIMEOUT_CYC + 1);

    localparam logic [SCAN_W-1:0] SCAN_TOP  = SCAN_W'(SCAN_MAX);
    localparam logic [SCAN_W-1:0] HOLD_N    = SCAN_W'(HOLD_SCANS);
    localparam logic [SCAN_W-1:0] GAP_LAST  = SCAN_W'(GAP_SCANS - 1);
    localparam logic [SCAN_W-1:0] SCAN_ONE  = SCAN_W'(1);
    localparam logic [TO_W-1:0]   TO_TOP    = TO_W'(TIMEOUT_CYC);
    localparam logic [TO_W-1:0]   TO_ONE    = TO_W'(1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PRESS   = 2'd1,
        S_RELEASE = 2'd2,
        S_DONE    = 2'd3
    } state_e;

    function automatic logic [3:0] onehot4(input logic [1:0] idx);
        onehot4 = 4'b0001 << idx;
    endfunction

    // -------------------------------------------------------------------------
    // Registers and next-state values
    // -------------------------------------------------------------------------
    state_e             state_q, state_d;

    logic [3:0]         col_meta_q;
    logic [3:0]         col_s_q;
    logic [3:0]         col_p_q;

    logic [3:0]         tgt_col_q, tgt_col_d;
    logic [3:0]         tgt_row_q, tgt_row_d;
    logic [SCAN_W-1:0]  scan_cnt_q, scan_cnt_d;
    logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
    logic [3:0]         fila_q, fila_d;
    logic               err_q, err_d;

    // -------------------------------------------------------------------------
    // Decoded conditions
    // -------------------------------------------------------------------------
    logic accept;
    logic running;
    logic on_target;
    logic match_edge;
    logic col_change;
    logic timeout;
    logic leave_press;
    logic release_done;

    assign accept     = key_valid && (state_q == S_IDLE);
    assign running    = (state_q == S_PRESS) || (state_q == S_RELEASE);
    // Exact compare: an invalid strobe (zero or multi-hot) never matches.
    assign on_target  = (col_s_q == tgt_col_q);
    assign match_edge = on_target && (col_p_q != tgt_col_q);
    assign col_change = (col_s_q != col_p_q);

    // The last hold window has ended once the strobe has moved off the target.
    assign leave_press  = (scan_cnt_q == HOLD_N) && !on_target;
    // The match edge that would bring the count up to GAP_SCANS.
    assign release_done = match_edge && (scan_cnt_q == GAP_LAST);

    // -------------------------------------------------------------------------
    // Datapath next-state logic
    // -------------------------------------------------------------------------
    // NOTE: every signal written in an always_comb gets a default on entry, so
    // no path can leave it unassigned and no latch is inferred.
    always_comb begin
        tgt_col_d  = tgt_col_q;
        tgt_row_d  = tgt_row_q;
        scan_cnt_d = scan_cnt_q;
        to_cnt_d   = '0;

        if (accept) begin
            tgt_col_d = onehot4(key_code[3:2]);
            tgt_row_d = onehot4(key_code[1:0]);
        end

        // Stall counter: any movement of the strobe restarts it; it only runs
        // while a sequence is active and holds at its terminal value.
        if (running && !col_change) begin
            to_cnt_d = (to_cnt_q == TO_TOP) ? to_cnt_q : to_cnt_q + TO_ONE;
        end

        case (state_q)
            S_PRESS: begin
                if (leave_press) begin
                    scan_cnt_d = '0;
                end else if (match_edge && scan_cnt_q != SCAN_TOP) begin
                    scan_cnt_d = scan_cnt_q + SCAN_ONE;
                end
            end
            S_RELEASE: begin
                if (match_edge && scan_cnt_q != SCAN_TOP) begin
                    scan_cnt_d = scan_cnt_q + SCAN_ONE;
                end
            end
            default: scan_cnt_d = '0;
        endcase

        if (timeout) begin
            scan_cnt_d = '0;
        end
    end

    // Timeout is decided on the increment that reaches TIMEOUT_CYC, so the
    // abort lands on the same edge the counter arrives at its terminal value.
    assign timeout = running && (to_cnt_d == TO_TOP);

    // Rows are driven only while pressed and only inside the target window.
    // An aborting cycle forces them low together with the return to IDLE.
    always_comb begin
        fila_d = 4'b0000;
        if (state_q == S_PRESS && on_target && !timeout) begin
            fila_d = tgt_row_q;
        end
    end

    assign err_d = timeout;

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of every other flop, independent of the
    // order of statements or processes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic (timeout takes priority over any advance)
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_PRESS;
                end
            end
            S_PRESS: begin
                if (timeout) begin
                    state_d = S_IDLE;
                end else if (leave_press) begin
                    state_d = S_RELEASE;
                end
            end
            S_RELEASE: begin
                if (timeout) begin
                    state_d = S_IDLE;
                end else if (release_done) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: outputs
    // -------------------------------------------------------------------------
    always_comb begin
        key_ready = (state_q == S_IDLE);
        busy      = (state_q != S_IDLE);
        done      = (state_q == S_DONE);
    end

    // err is registered on the aborting edge, so it is seen in IDLE and can
    // never coincide with done, which is only high in S_DONE.
    assign err  = err_q;
    // fila comes straight from a flop with asynchronous clear, so a reset
    // releases the rows without waiting for a clock edge.
    assign fila = fila_q;

    // -------------------------------------------------------------------------
    // Datapath registers, including the two-flop column synchronizer and the
    // one-cycle delayed copy used for edge and change detection.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_meta_q <= 4'b0000;
            col_s_q    <= 4'b0000;
            col_p_q    <= 4'b0000;
            tgt_col_q  <= 4'b0000;
            tgt_row_q  <= 4'b0000;
            scan_cnt_q <= '0;
            to_cnt_q   <= '0;
            fila_q     <= 4'b0000;
            err_q      <= 1'b0;
        end else begin
            col_meta_q <= col;
            col_s_q    <= col_meta_q;
            col_p_q    <= col_s_q;
            tgt_col_q  <= tgt_col_d;
            tgt_row_q  <= tgt_row_d;
            scan_cnt_q <= scan_cnt_d;
            to_cnt_q   <= to_cnt_d;
            fila_q     <= fila_d;
            err_q      <= err_d;
        end
    end

endmodule

// File: tb/tb_keypad_emulator.sv
// -----------------------------------------------------------------------------
// tb_keypad_emulator
//
// Drives a rotating one-hot column strobe (8 clk per column) and key offers.
// For every column value driven, the expected row/done/err seen three clocks
// later is pushed to a scoreboard queue and popped on the following negedges.
// Expectations come from a window-level model of the keypad behaviour.
// -----------------------------------------------------------------------------
module tb_keypad_emulator;

    localparam int HOLD = 2;
    localparam int GAP  = 1;
    localparam int TO   = 64;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] col;
    logic [3:0] fila;
    logic       key_valid;
    logic [3:0] key_code;
    logic       key_ready;
    logic       busy;
    logic       done;
    logic       err;

    keypad_emulator #(
        .HOLD_SCANS (HOLD),
        .GAP_SCANS  (GAP),
        .TIMEOUT_CYC(TO)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .col      (col),
        .fila     (fila),
        .key_valid(key_valid),
        .key_code (key_code),
        .key_ready(key_ready),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] fila;
        logic       done;
        logic       err;
    } exp_t;

    exp_t       exp_q[$];
    logic [3:0] inv_q[$];

    int n_checks;
    int n_errors;

    // stimulus state
    int         cyc;
    int         ph;
    bit         freeze;
    logic [3:0] prev_base;
    bit         inv_on;
    logic [3:0] cur_inv;
    bit         drv_kv;
    logic [3:0] drv_code;
    bit         auto_drop;

    // model state
    bit         m_active;
    bit         m_busy;
    bit         rel_pending;
    bit         acc_pend;
    int         acc_iter;
    int         m_win;
    int         m_last_chg;
    logic [3:0] m_prev_col;
    logic [3:0] m_tgt_col;
    logic [3:0] m_tgt_row;
    logic [3:0] last_exp_fila;
    int         seq_cnt;
    int         n_done;
    int         n_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    // One clock: compare at negedge, then drive the next inputs.
    task automatic tick();
        exp_t       e;
        logic [3:0] base;
        logic [3:0] c;
        @(negedge clk);
        cyc++;

        if (rel_pending) begin
            m_busy      = 1'b0;
            rel_pending = 1'b0;
            seq_cnt++;
        end
        if (acc_pend && cyc == acc_iter + 1) begin
            m_busy   = 1'b1;
            acc_pend = 1'b0;
        end
        e = exp_q.pop_front();
        if (e.done) rel_pending = 1'b1;
        if (e.err) begin
            m_busy = 1'b0;
            seq_cnt++;
        end
        last_exp_fila = e.fila;
        check("fila",      32'(fila),      32'(e.fila));
        check("done",      32'(done),      32'(e.done));
        check("err",       32'(err),       32'(e.err));
        check("key_ready", 32'(key_ready), 32'(!m_busy));
        check("busy",      32'(busy),      32'(m_busy));
        if (done === 1'b1) n_done++;
        if (err === 1'b1) n_err++;

        // column generation, with optional corruption of whole target windows
        base = 4'b0001 << ((ph / 8) % 4);
        if (base != prev_base) begin
            inv_on = (base == 4'b0010) && (inv_q.size() > 0);
            if (inv_on) cur_inv = inv_q.pop_front();
        end
        prev_base = base;
        c = inv_on ? cur_inv : base;
        if (!freeze) ph++;
        col       = c;
        key_valid = drv_kv;
        key_code  = drv_code;

        // expected outputs three clocks from now
        e = '0;
        if (c != m_prev_col) m_last_chg = cyc;
        if (m_active) begin
            if (cyc - m_last_chg >= TO) begin
                e.err    = 1'b1;
                m_active = 1'b0;
            end else begin
                if (c == m_tgt_col && m_prev_col != m_tgt_col) begin
                    m_win++;
                    if (m_win == HOLD + GAP) begin
                        e.done   = 1'b1;
                        m_active = 1'b0;
                    end
                end
                if (m_active && c == m_tgt_col && m_win >= 1 && m_win <= HOLD)
                    e.fila = m_tgt_row;
            end
        end
        m_prev_col = c;
        exp_q.push_back(e);

        // handshake: accepted when offered while the model is idle
        if (drv_kv && !m_busy) begin
            m_active  = 1'b1;
            m_win     = 0;
            m_tgt_col = 4'b0001 << drv_code[3:2];
            m_tgt_row = 4'b0001 << drv_code[1:0];
            acc_iter  = cyc;
            acc_pend  = 1'b1;
            if (auto_drop) drv_kv = 1'b0;
        end
    endtask

    task automatic flush_model();
        exp_q.delete();
        inv_q.delete();
        repeat (3) exp_q.push_back('0);
        m_active    = 1'b0;
        m_busy      = 1'b0;
        rel_pending = 1'b0;
        acc_pend    = 1'b0;
        m_win       = 0;
        inv_on      = 1'b0;
        freeze      = 1'b0;
        drv_kv      = 1'b0;
    endtask

    // Advance until the next drive lands two clocks into the column window two
    // steps ahead of the key's column, well clear of any target window.
    task automatic wait_phase(input int idx);
        int target;
        target = (idx + 2) % 4;
        for (int i = 0; i < 40 && !(((ph / 8) % 4) == target && (ph % 8) == 2); i++) tick();
    endtask

    task automatic offer(input logic [3:0] code);
        wait_phase(int'(code[3:2]));
        drv_kv    = 1'b1;
        drv_code  = code;
        auto_drop = 1'b1;
        tick();
    endtask

    task automatic run_seqs(input int n, input int budget, input int want_done, input int want_err);
        int s0;
        int d0;
        int e0;
        s0 = seq_cnt;
        d0 = n_done;
        e0 = n_err;
        for (int i = 0; i < budget && seq_cnt < s0 + n; i++) tick();
        check("done_pulses", 32'(n_done - d0), 32'(want_done));
        check("err_pulses",  32'(n_err - e0),  32'(want_err));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_fila"},  32'(fila),      32'(4'b0000));
        check({tag, "_ready"}, 32'(key_ready), 32'(1'b1));
        check({tag, "_busy"},  32'(busy),      32'(1'b0));
        check({tag, "_done"},  32'(done),      32'(1'b0));
        check({tag, "_err"},   32'(err),       32'(1'b0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        cyc       = 0;
        ph        = 0;
        prev_base = 4'b0000;
        cur_inv   = 4'b0000;
        drv_code  = 4'h0;
        auto_drop = 1'b0;
        acc_iter  = 0;
        m_last_chg = 0;
        m_prev_col = 4'b0001;
        m_tgt_col  = 4'b0000;
        m_tgt_row  = 4'b0000;
        last_exp_fila = 4'b0000;
        seq_cnt   = 0;
        n_done    = 0;
        n_err     = 0;
        flush_model();

        rst_n     = 1'b1;
        col       = 4'b0001;
        key_valid = 1'b0;
        key_code  = 4'h0;

        // 1. reset values, then 100 idle cycles
        #1 rst_n = 1'b0;
        #2 check_reset_outputs("rst");
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (100) tick();
        check("idle_done_pulses", 32'(n_done), 32'(0));
        check("idle_err_pulses",  32'(n_err),  32'(0));

        // 2. key 6: row 0100 in column 0010 windows, two held, one released
        offer(4'h6);
        run_seqs(1, 300, 1, 0);
        check("ready_after_done", 32'(key_ready), 32'(1'b1));

        // 3. busy rejection: 4'h0 held during the 4'hF sequence, taken after
        offer(4'hF);
        drv_kv   = 1'b1;
        drv_code = 4'h0;
        run_seqs(2, 600, 2, 0);
        check("kv_dropped_after_accept", 32'(key_valid), 32'(1'b0));

        // 4. timeout: strobe frozen on the target column during the press
        offer(4'h6);
        for (int i = 0; i < 64 && m_win < 1; i++) tick();
        freeze = 1'b1;
        run_seqs(1, 200, 0, 1);
        freeze = 1'b0;
        check("ready_after_err", 32'(key_ready), 32'(1'b1));

        // 5. invalid strobes replace two target windows; they must not count
        offer(4'h6);
        inv_q.push_back(4'b0011);
        inv_q.push_back(4'b0000);
        run_seqs(1, 400, 1, 0);

        // 6. asynchronous reset while the key is shown pressed
        offer(4'h6);
        for (int i = 0; i < 64 && last_exp_fila != 4'b0100; i++) tick();
        repeat (2) tick();
        check("fila_pre_rst", 32'(fila), 32'(4'b0100));
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("async_rst");
        flush_model();
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (20) tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
